sw_conditioner: RTL
===================

Name: sw_conditioner

Overview:
- Input conditioning stage directly upstream of tt_Maquina_Top (vending machine FSM).
- Takes the four raw user switches P, R, N, D (ui_in[6:3]), then synchronizes, debounces and edge-detects them.
- Issues at most one single-cycle, one-hot event pulse per clock, so the FSM never sees bounce, metastability or simultaneous coin/selection events.
- Also exports the clean debounced levels.

Parameters:
- NUM_SW, 4, number of switch channels (bit 3 = D, 2 = N, 1 = R, 0 = P).
- DEBOUNCE_CYCLES, 100000, consecutive stable cycles required before the debounced level changes (10 ms at 10 MHz); legal range 1..2^CNT_W-1.
- CNT_W, 17, width of each per-channel debounce counter.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- sw_raw  input  NUM_SW  raw asynchronous switch inputs.
- sw_level  output  NUM_SW  debounced switch levels.
- sw_pulse  output  NUM_SW  one-hot (or zero) single-cycle event on debounced rising edge.
- overrun  output  1  sticky flag: a rising edge was lost because that channel was already pending.

Behaviour:
- Reset (asynchronous, active-high, any time including mid-debounce or mid-issue):
  - Sync flops, counters, sw_level, pending and sw_pulse all go to 0; overrun goes to 0.
  - Outputs hold 0 while reset is high.
  - After release, the first edge resumes normal sampling.
- Synchronizer: two flops per bit (s1 <= sw_raw, s2 <= s1). No logic between s1 and s2.
- Debounce, per channel:
  - If s2 == sw_level: counter cleared.
  - If s2 != sw_level and counter < DEBOUNCE_CYCLES-1: counter increments.
  - If s2 != sw_level and counter == DEBOUNCE_CYCLES-1: sw_level toggles and counter clears.
  - Any cycle where s2 returns to sw_level before the limit restarts the count. Glitches shorter than DEBOUNCE_CYCLES never change sw_level.
  - The counter never wraps.
- Edge detect: a registered copy of sw_level gives rise = sw_level & ~sw_level_d. Falling edges produce no event.
- Pending register (NUM_SW bits):
  - A rise sets its pending bit on the next edge.
  - If that bit is already set and is not being issued in the same cycle, the new rise is dropped and overrun is set (sticky until reset).
- Issue logic:
  - Each cycle, if pending != 0, the highest-index set bit is selected (D > N > R > P).
  - sw_pulse is registered to that one-hot value for exactly one cycle, and that pending bit is cleared.
  - Otherwise sw_pulse = 0.
- Simultaneous issue and new rise on the same bit: the bit stays pending (second event preserved, no overrun).
- Invariant: sw_pulse is never multi-hot and never high for two consecutive cycles on the same bit unless two distinct edges were pending.
- Latency: edge 0 is the first clock edge sampling sw_raw high into s1.
  - s2 is high after edge 1.
  - sw_level is high after edge DEBOUNCE_CYCLES+1.
  - pending is set at edge DEBOUNCE_CYCLES+2.
  - With pending otherwise empty, sw_pulse is high after edge DEBOUNCE_CYCLES+3 for one cycle.
- Release: sw_level falls at the same latency; no pulse is generated.
- Fully synchronous to clk apart from the asynchronous reset. No combinational path from sw_raw to any output.

Test Plan:
- Clean press, DEBOUNCE_CYCLES=4: sw_raw[0] 0->1 held 20 cycles -> sw_level[0] rises 5 edges after first sample; sw_pulse = 4'b0001 for exactly 1 cycle, 7 edges after first sample; release gives no pulse; overrun = 0.
- Bounce, DEBOUNCE_CYCLES=4: sw_raw[2] toggles with highs of 1, 2 and 3 cycles, then holds high -> no sw_level change during the bounce; exactly one sw_pulse = 4'b0100, 7 edges after the final stable high begins.
- Simultaneous press: sw_raw = 4'b1111 in one cycle -> pulses 4'b1000, 4'b0100, 4'b0010, 4'b0001 on four consecutive cycles, never multi-hot; overrun = 0.
- Overrun: bit 0 pending behind a higher-priority stream (bits 3..1 pulsed repeatedly) while bit 0 gets a second debounced rise -> overrun = 1 and stays 1; bit 0 pulses once only.
- Reset mid-operation: assert reset while counter = 2 and pending = 4'b0110 -> all outputs 0 immediately (asynchronous); after release with sw_raw held high, full latency restarts and exactly one pulse per held-high bit is issued.
- Default parameters: DEBOUNCE_CYCLES=100000 with a 99999-cycle high -> no change; a 100000-cycle high -> sw_level toggles; counter does not wrap.

Source files
------------

// File: rtl/sw_conditioner.sv
// Switch conditioning for the vending machine FSM: 2-flop sync, per-channel debounce,
// rising-edge detect and a priority issuer that emits at most one one-hot pulse per clock.
module sw_conditioner #(
  parameter int NUM_SW          = 4,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_SW-1:0] sw_raw,
  output logic [NUM_SW-1:0] sw_level,
  output logic [NUM_SW-1:0] sw_pulse,
  output logic              overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [NUM_SW-1:0] sync1_q;
  logic [NUM_SW-1:0] sync2_q;
  logic [NUM_SW-1:0] level_q;
  logic [NUM_SW-1:0] level_d;
  logic [NUM_SW-1:0] level_dly_q;
  logic [NUM_SW-1:0] pending_q;
  logic [NUM_SW-1:0] pending_d;
  logic [NUM_SW-1:0] pulse_q;
  logic              overrun_q;
  logic              overrun_d;
  logic [CNT_W-1:0]  cnt_q [NUM_SW];
  logic [CNT_W-1:0]  cnt_d [NUM_SW];
  logic [NUM_SW-1:0] rise_s;
  logic [NUM_SW-1:0] grant_s;
  logic              found_s;

  // Debounce: the level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < NUM_SW; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        level_d[i] = ~level_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Issue: highest pending index wins; a bit issued this cycle may be re-armed by a new rise.
  always_comb begin
    rise_s  = level_q & ~level_dly_q;
    grant_s = '0;
    found_s = 1'b0;
    for (int i = NUM_SW - 1; i >= 0; i--) begin
      if (pending_q[i] && !found_s) begin
        grant_s[i] = 1'b1;
        found_s    = 1'b1;
      end else begin
        grant_s[i] = 1'b0;
      end
    end
    pending_d = (pending_q & ~grant_s) | rise_s;
    overrun_d = overrun_q | (|(rise_s & pending_q & ~grant_s));
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      level_dly_q <= '0;
      pending_q   <= '0;
      pulse_q     <= '0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < NUM_SW; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q     <= sw_raw;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      pending_q   <= pending_d;
      pulse_q     <= grant_s;
      overrun_q   <= overrun_d;
      for (int i = 0; i < NUM_SW; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sw_level = level_q;
  assign sw_pulse = pulse_q;
  assign overrun  = overrun_q;

endmodule
